// File: rtl/clink_frame_gen.sv
// Camera Link base-configuration frame generator: FVAL/LVAL/DVAL timing plus
// 3-tap 8-bit test patterns, packed as one 28-bit word per pixel clock.
module clink_frame_gen #(
  parameter int LINES = 4,
  parameter int CW    = 12
) (
  input  logic               px_clk,
  input  logic               reset,
  input  logic               tx_ready,
  input  logic               start,
  input  logic               stop,
  input  logic [CW-1:0]      cfg_h_active,
  input  logic [CW-1:0]      cfg_v_active,
  input  logic [CW-1:0]      cfg_h_blank,
  input  logic [CW-1:0]      cfg_v_blank,
  input  logic [7:0]         cfg_frames,
  input  logic [1:0]         cfg_pattern,
  output logic [7*LINES-1:0] px_data,
  output logic               fval,
  output logic               lval,
  output logic               dval,
  output logic               busy,
  output logic               frame_done,
  output logic               aborted
);

  localparam int PW = 7 * LINES;

  typedef enum logic [2:0] {IDLE, F_SETUP, LINE, L_GAP, F_GAP} state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [CW-1:0] y, nxt_y;
  logic [7:0]    index, nxt_index;
  logic          stop_seen, nxt_stop;
  logic          nxt_aborted;
  logic          load;
  logic          done;

  logic [CW-1:0] sh_h_active, sh_v_active, sh_h_blank, sh_v_blank;
  logic [7:0]    sh_frames;
  logic [1:0]    sh_pattern;

  logic [7:0]    x8, tap_a, tap_b, tap_c;
  logic [27:0]   word;

  function automatic logic [CW-1:0] at_least_one(input logic [CW-1:0] v);
    return (v == '0) ? {{(CW-1){1'b0}}, 1'b1} : v;
  endfunction

  // Every state runs a clock counter up to its (shadowed) length minus one,
  // so a length of 2^CW-1 never needs a CW+1-bit value.
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_y       = y;
    nxt_index   = index;
    nxt_stop    = stop_seen;
    nxt_aborted = aborted;
    load        = 1'b0;
    done        = 1'b0;
    if (state == IDLE) begin
      if (start && tx_ready) begin
        nxt_state   = F_SETUP;
        nxt_cnt     = '0;
        nxt_y       = '0;
        nxt_index   = '0;
        nxt_stop    = 1'b0;
        nxt_aborted = 1'b0;
        load        = 1'b1;
      end
    end else if (!tx_ready) begin
      nxt_state   = IDLE;
      nxt_cnt     = '0;
      nxt_stop    = 1'b0;
      nxt_aborted = 1'b1;
    end else begin
      nxt_stop = stop_seen | stop;
      case (state)
        F_SETUP, L_GAP: begin
          if (cnt == sh_h_blank - 1'b1) begin
            nxt_state = LINE;
            nxt_cnt   = '0;
            nxt_y     = (state == F_SETUP) ? '0 : y + 1'b1;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        LINE: begin
          if (cnt == sh_h_active - 1'b1) begin
            nxt_cnt = '0;
            if (y == sh_v_active - 1'b1) begin
              nxt_state = F_GAP;
              nxt_index = index + 1'b1;
              done      = 1'b1;
            end else begin
              nxt_state = L_GAP;
            end
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        F_GAP: begin
          if (cnt == sh_v_blank - 1'b1) begin
            nxt_cnt = '0;
            nxt_y   = '0;
            if (nxt_stop || (sh_frames != 8'd0 && index == sh_frames)) begin
              nxt_state = IDLE;
            end else begin
              nxt_state = F_SETUP;
            end
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Pixel bytes are derived from the next-cycle position so they register
  // alongside the valids they belong to.
  always_comb begin
    x8    = nxt_cnt[7:0];
    tap_a = 8'h00;
    tap_b = 8'h00;
    tap_c = 8'h00;
    if (nxt_state == LINE) begin
      case (sh_pattern)
        2'd0: begin
          tap_a = {x8[6:0], 1'b0} + x8;
          tap_b = tap_a + 8'd1;
          tap_c = tap_a + 8'd2;
        end
        2'd1: begin
          tap_a = nxt_y[7:0];
          tap_b = nxt_y[7:0];
          tap_c = nxt_y[7:0];
        end
        2'd2: begin
          tap_a = {8{nxt_cnt[3] ^ nxt_y[3]}};
          tap_b = tap_a;
          tap_c = tap_a;
        end
        default: begin
          tap_a = nxt_index;
          tap_b = nxt_index;
          tap_c = nxt_index;
        end
      endcase
    end
    word = {1'b0, nxt_state == LINE,
            nxt_state == F_SETUP || nxt_state == LINE || nxt_state == L_GAP,
            nxt_state == LINE, tap_c, tap_b, tap_a};
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      y           <= '0;
      index       <= '0;
      stop_seen   <= 1'b0;
      sh_h_active <= '0;
      sh_v_active <= '0;
      sh_h_blank  <= '0;
      sh_v_blank  <= '0;
      sh_frames   <= '0;
      sh_pattern  <= '0;
      px_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      y          <= nxt_y;
      index      <= nxt_index;
      stop_seen  <= nxt_stop;
      px_data    <= PW'(word);
      busy       <= (nxt_state != IDLE);
      frame_done <= done;
      aborted    <= nxt_aborted;
      if (load) begin
        sh_h_active <= at_least_one(cfg_h_active);
        sh_v_active <= at_least_one(cfg_v_active);
        sh_h_blank  <= at_least_one(cfg_h_blank);
        sh_v_blank  <= at_least_one(cfg_v_blank);
        sh_frames   <= cfg_frames;
        sh_pattern  <= cfg_pattern;
      end
    end
  end

  assign lval = px_data[24];
  assign fval = px_data[25];
  assign dval = px_data[26];

endmodule

// File: tb/tb_clink_frame_gen.sv
// Bench for clink_frame_gen: a line/frame-level model expands each
// configuration into the expected per-clock output trace.
module tb_clink_frame_gen;

  localparam int CW = 12;

  logic          px_clk;
  logic          reset;
  logic          tx_ready;
  logic          start;
  logic          stop;
  logic [CW-1:0] cfg_h_active;
  logic [CW-1:0] cfg_v_active;
  logic [CW-1:0] cfg_h_blank;
  logic [CW-1:0] cfg_v_blank;
  logic [7:0]    cfg_frames;
  logic [1:0]    cfg_pattern;
  logic [27:0]   px_data;
  logic          fval, lval, dval, busy, frame_done, aborted;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [33:0] exp_q[$];

  clink_frame_gen #(.LINES(4), .CW(CW)) dut (
    .px_clk(px_clk), .reset(reset), .tx_ready(tx_ready), .start(start), .stop(stop),
    .cfg_h_active(cfg_h_active), .cfg_v_active(cfg_v_active),
    .cfg_h_blank(cfg_h_blank), .cfg_v_blank(cfg_v_blank),
    .cfg_frames(cfg_frames), .cfg_pattern(cfg_pattern),
    .px_data(px_data), .fval(fval), .lval(lval), .dval(dval),
    .busy(busy), .frame_done(frame_done), .aborted(aborted)
  );

  initial begin
    px_clk = 1'b0;
    forever #5 px_clk = ~px_clk;
  end

  function automatic logic [33:0] mk(input bit f, input bit l, input bit d,
                                     input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                                     input bit bsy, input bit dn, input bit ab);
    logic [27:0] px;
    px = {1'b0, d, f, l, c, b, a};
    return {px, f, l, d, bsy, dn, ab};
  endfunction

  function automatic logic [7:0] pix(input int pat, input int x, input int y, input int f, input int k);
    case (pat)
      0:       return 8'((3 * x + k) % 256);
      1:       return 8'(y % 256);
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      default: return 8'(f % 256);
    endcase
  endfunction

  // Each line is its blanking followed by its data; the frame's first blanking
  // is the setup period after FVAL rises.
  function automatic void build_model(input int ha, input int va, input int hb, input int vb,
                                      input int nf, input int pat);
    if (ha == 0) ha = 1;
    if (va == 0) va = 1;
    if (hb == 0) hb = 1;
    if (vb == 0) vb = 1;
    exp_q.delete();
    for (int f = 0; f < nf; f++) begin
      for (int y = 0; y < va; y++) begin
        for (int j = 0; j < hb; j++)
          exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
        for (int x = 0; x < ha; x++)
          exp_q.push_back(mk(1'b1, 1'b1, 1'b1, pix(pat, x, y, f, 0), pix(pat, x, y, f, 1),
                             pix(pat, x, y, f, 2), 1'b1, 1'b0, 1'b0));
      end
      for (int j = 0; j < vb; j++)
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, j == 0, 1'b0));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
  endfunction

  task automatic checkOutput(input string tag, input logic [33:0] exp_v);
    logic [33:0] act;
    act = {px_data, fval, lval, dval, busy, frame_done, aborted};
    checks++;
    assert (act === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, act, exp_v);
    end
  endtask

  // Pulses start with the given configuration, then scrambles cfg_* so that
  // only the values captured at start can produce the modelled trace.
  task automatic applyStimulus(input int ha, input int va, input int hb, input int vb,
                               input int fr, input int pat, input int nf);
    cfg_h_active = CW'(ha);
    cfg_v_active = CW'(va);
    cfg_h_blank  = CW'(hb);
    cfg_v_blank  = CW'(vb);
    cfg_frames   = 8'(fr);
    cfg_pattern  = 2'(pat);
    start = 1'b1;
    @(negedge px_clk);
    start = 1'b0;
    cfg_h_active = CW'($urandom);
    cfg_v_active = CW'($urandom);
    cfg_h_blank  = CW'($urandom);
    cfg_v_blank  = CW'($urandom);
    cfg_frames   = 8'($urandom);
    cfg_pattern  = 2'($urandom);
    build_model(ha, va, hb, vb, nf, pat);
  endtask

  task automatic runModel(input string tag, input int stop_at, input int start_at, input int limit);
    done_cnt = 0;
    for (int i = 0; i < exp_q.size() && i < limit; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), exp_q[i]);
      if (frame_done) done_cnt++;
      if (i == stop_at) stop = 1'b1;
      if (i == start_at) start = 1'b1;
      @(negedge px_clk);
      stop  = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    logic [33:0] idle_v, abort_v;
    int ha, va, hb, vb, fr, pat;
    idle_v  = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    abort_v = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    reset = 1'b1; tx_ready = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_h_active = '0; cfg_v_active = '0; cfg_h_blank = '0; cfg_v_blank = '0;
    cfg_frames = '0; cfg_pattern = '0;
    repeat (3) @(negedge px_clk);
    checkOutput("reset_hold", idle_v);
    reset = 1'b0;
    @(negedge px_clk);
    checkOutput("post_reset", idle_v);

    $display("[TB] basic single frame, h-ramp");
    applyStimulus(4, 2, 2, 3, 1, 0, 1);
    runModel("basic", -1, -1, 1 << 30);

    $display("[TB] three frames, frame-index pattern");
    applyStimulus(4, 2, 2, 3, 3, 3, 3);
    runModel("findex", -1, -1, 1 << 30);
    checks++;
    assert (done_cnt === 3) else begin
      errors++;
      $error("[TB] FAIL done_pulses: observed=%0d expected=3", done_cnt);
    end

    $display("[TB] continuous, stop mid-line of frame 2, checker");
    applyStimulus(10, 9, 2, 2, 0, 2, 2);
    runModel("stop", 9 * 12 + 2 + 2 + 3, -1, 1 << 30);
    checkOutput("no_frame3", idle_v);

    $display("[TB] tx_ready loss during a line");
    applyStimulus(4, 2, 2, 3, 1, 0, 1);
    runModel("pre_abort", -1, -1, 5);
    tx_ready = 1'b0;
    @(negedge px_clk);
    checkOutput("abort", abort_v);
    start = 1'b1;
    @(negedge px_clk);
    start = 1'b0;
    checkOutput("start_no_ready", abort_v);
    tx_ready = 1'b1;
    @(negedge px_clk);
    checkOutput("ready_back", abort_v);
    applyStimulus(3, 1, 1, 1, 1, 1, 1);
    runModel("after_abort", -1, -1, 1 << 30);

    $display("[TB] all-zero config, start while busy, stop");
    applyStimulus(0, 0, 0, 0, 0, 0, 2);
    runModel("zeros", 3, 1, 1 << 30);

    $display("[TB] reset mid-frame then restart");
    applyStimulus(5, 3, 2, 2, 2, 0, 2);
    runModel("pre_reset", -1, -1, 9);
    reset = 1'b1;
    @(negedge px_clk);
    checkOutput("mid_reset", idle_v);
    reset = 1'b0;
    @(negedge px_clk);
    applyStimulus(5, 3, 2, 2, 2, 0, 2);
    runModel("post_reset_frame", -1, -1, 1 << 30);

    $display("[TB] randomized configurations");
    for (int r = 0; r < 6; r++) begin
      ha  = $urandom_range(12, 0);
      va  = $urandom_range(4, 0);
      hb  = $urandom_range(3, 0);
      vb  = $urandom_range(3, 0);
      fr  = $urandom_range(3, 1);
      pat = $urandom_range(3, 0);
      applyStimulus(ha, va, hb, vb, fr, pat, fr);
      runModel($sformatf("rand%0d", r), -1, -1, 1 << 30);
    end

    $display("[TB] maximum counter values");
    applyStimulus(4095, 1, 4095, 4095, 1, 0, 1);
    runModel("max_h", -1, -1, 1 << 30);
    applyStimulus(1, 4095, 1, 1, 1, 1, 1);
    runModel("max_v", -1, -1, 1 << 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clink_frame_gen.md
# clink_frame_gen

Camera Link base-configuration frame generator: produces FVAL/LVAL/DVAL timing and 3-tap 8-bit pixel data as a packed 28-bit-per-clock word, ready for a 7:1 LVDS serializer. It acts as the camera end of the link. It drives the team's Camera Link receive path in loopback for bring-up, and supplies known test patterns for the image pipeline without a physical camera. Control inputs come from an AXI register block in the same clock domain.

## Interface
- LINES, 4, number of serializer data lines; px_data width is 7*LINES (only 4 supported)
- CW, 12, width of line/frame size and blanking configuration inputs
- px_clk  in  1  pixel clock; the only clock
- reset  in  1  synchronous, active-high
- tx_ready  in  1  serializer ready; low forces outputs idle
- start  in  1  single-cycle request to begin a frame sequence
- stop  in  1  single-cycle request to finish the current frame, then idle
- cfg_h_active  in  CW  data clocks per line (3 pixels per clock); 0 treated as 1
- cfg_v_active  in  CW  lines per frame; 0 treated as 1
- cfg_h_blank  in  CW  clocks with LVAL low between lines, and after FVAL rise; 0 treated as 1
- cfg_v_blank  in  CW  clocks with FVAL low between frames; 0 treated as 1
- cfg_frames  in  8  frames to send; 0 = continuous until stop
- cfg_pattern  in  2  0 h-ramp, 1 v-ramp, 2 checker, 3 frame index
- px_data  out  7*LINES  packed word: [7:0] port A, [15:8] port B, [23:16] port C, [24] LVAL, [25] FVAL, [26] DVAL, [27] 0
- fval, lval, dval  out  1  copies of px_data[25], [24], [26]
- busy  out  1  sequence in progress
- frame_done  out  1  one-cycle pulse per completed frame
- aborted  out  1  sticky; set on tx_ready loss mid-sequence; cleared by the next accepted start

## Operation
- States: IDLE, F_SETUP, LINE, L_GAP, F_GAP.
- cfg_* inputs are sampled into shadow registers when start is accepted. They are ignored at all other times.
- IDLE: start && tx_ready accepted. Clears the frame index and aborted, loads shadows, and moves to F_SETUP. start while busy, or while tx_ready is low, is ignored.
- F_SETUP: FVAL=1, LVAL=0, for h_blank clocks, then LINE with y=0.
- LINE: FVAL=LVAL=DVAL=1 for h_active clocks, with x = 0..h_active-1.
  - If y < v_active-1: go to L_GAP.
  - Otherwise: go to F_GAP.
- L_GAP: FVAL=1, LVAL=0, for h_blank clocks; y++ then LINE.
- F_GAP: all valids 0 for v_blank clocks. frame_done pulses on the first F_GAP clock and the frame index increments.
- At F_GAP end, go to IDLE if any of these holds; otherwise go to F_SETUP:
  - stop was seen during the frame;
  - cfg_frames != 0 and the frame index == cfg_frames.
- Pattern per tap k (A=0, B=1, C=2), all 8-bit truncated:
  - h-ramp: 3x+k
  - v-ramp: y
  - checker: 0xFF if x[3]^y[3] else 0x00
  - frame index: index[7:0]
- Pixel bytes are 0 whenever DVAL=0.
- tx_ready low in any non-IDLE state: go to IDLE immediately, set aborted, no frame_done.
- stop in IDLE has no effect. stop and start in the same IDLE cycle: start wins, and stop is not latched.

## Timing
- All outputs are registered. Reset values: px_data=0, fval=lval=dval=0, busy=0, frame_done=0, aborted=0, state IDLE.
- Start accepted at edge N: at N+1, busy=1, fval=1, lval=0.
- First lval=1 appears at N+1+h_blank.
- Line period is h_active+h_blank clocks. Frame period is v_active*(h_active+h_blank)+v_blank clocks.
- FVAL falls on the clock after the last data clock of the last line. There is no trailing L_GAP.
- busy falls on the clock after the last F_GAP clock. A new start is accepted on that same clock.
- tx_ready sampled low at edge M: at M+1, all valids are 0, px_data=0, busy=0, aborted=1.
- Reset asserted mid-frame: at the next edge, all outputs take their reset values.
- Counters are CW bits. Setting cfg_* to 2^CW-1 must not wrap early.

## Test plan
- h_active=4, v_active=2, h_blank=2, v_blank=3, frames=1, pattern 0, start at cycle 10:
  - fval high on cycles 11–22;
  - lval high on 13–16 and 19–22;
  - port A/B/C on the first line = 00/01/02, 03/04/05, 06/07/08, 09/0A/0B;
  - frame_done at 23, busy low at 26.
- frames=3, pattern 3: three frames with pixel bytes 00, 01, 02; exactly 3 frame_done pulses; frame period matches the formula.
- frames=0, stop pulsed mid-line of frame 2: frame 2 completes in full, then IDLE; no frame 3.
- tx_ready dropped during LINE: next clock all valids 0, aborted=1, no frame_done; a new start clears aborted.
- All cfg_* = 0: behaves as 1 (a single 1-clock line per frame); start while busy is ignored.
- Reset asserted mid-frame, released, then start: the first frame has timing and data identical to a post-power-up frame.
